// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage feeding one IF/ID slot,
// with MIPS-style branch delay slot handling and redirect targets resolved in decode.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating delivered/bubble
// counters; without it both counter outputs are tied to zero.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] req_pc;
    logic        pending;
    logic        pending_next;
    logic [31:0] pending_target;
    logic [31:0] pending_target_next;

    logic        consume;
    logic        issue;
    logic        response;
    logic        redirect;
    logic        slot_unissued;
    logic        slot_issued;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign consume       = valid_id & ~stall;
    assign issue         = imem_req & imem_ready;
    assign response      = (state == WAIT) & imem_rvalid;
    assign redirect      = consume & (jump_branch | jump_target | jump_reg);
    assign pc_plus4      = pc_id + 32'd4;
    assign slot_unissued = (fetch_pc == pc_plus4);
    assign slot_issued   = (fetch_pc == pc_id + 32'd8);
    assign imem_addr     = fetch_pc;

    // Redirect target for the instruction in the IF/ID slot (register > jump > branch)
    always_comb begin
        target = pc_plus4 + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
        if (jump_reg) begin
            target = jr_pc;
        end else if (jump_target) begin
            target = {pc_plus4[31:28], instr_id[25:0], 2'b00};
        end
    end

    // FSM next state and request strobe; a request only goes out when the slot is free or draining
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req = ~valid_id | consume;
                if (imem_req && imem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetch PC sequencing: the delay slot is always fetched before the target.
    // When the slot has not issued yet, the target is parked until the slot's issue
    // (or applied at once if the slot issues in the same cycle as the redirect).
    always_comb begin
        fetch_pc_next       = fetch_pc;
        pending_next        = pending;
        pending_target_next = pending_target;
        if (redirect && slot_issued) begin
            fetch_pc_next = target;
        end else if (issue) begin
            if (redirect && slot_unissued) begin
                fetch_pc_next = target;
            end else if (pending) begin
                fetch_pc_next = pending_target;
                pending_next  = 1'b0;
            end else begin
                fetch_pc_next = fetch_pc + 32'd4;
            end
        end else if (redirect && slot_unissued) begin
            pending_next        = 1'b1;
            pending_target_next = target;
        end
    end

    // State, fetch PC, outstanding request address and redirect bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            fetch_pc       <= RESET_PC;
            req_pc         <= '0;
            pending        <= 1'b0;
            pending_target <= '0;
        end else begin
            state          <= state_next;
            fetch_pc       <= fetch_pc_next;
            pending        <= pending_next;
            pending_target <= pending_target_next;
            if (issue) begin
                req_pc <= fetch_pc;
            end
        end
    end

    // IF/ID slot: load on response, empty on consume (instruction word reads zero when empty)
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_id <= 1'b0;
            pc_id    <= '0;
            instr_id <= '0;
        end else if (response) begin
            valid_id <= 1'b1;
            pc_id    <= req_pc;
            instr_id <= imem_rdata;
        end else if (consume) begin
            valid_id <= 1'b0;
            instr_id <= '0;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    // Saturating delivered-instruction and empty-slot counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (response && fetch_cnt != '1) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!valid_id && state != IDLE && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt;
    assign bubble_count = bubble_cnt;
`else
    assign fetch_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors plus randomized traffic for fetch_unit.
// Expected delivery order comes from a program-order model: each instruction is
// followed by pc+4, except that after a redirect at P the stream is P+4 then target.
// Counter checks follow FETCH_PERF_COUNTERS_EN exactly as the design does.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int KB = 1;
    localparam int KJ = 2;
    localparam int KR = 3;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump_branch;
    logic        jump_target;
    logic        jump_reg;
    logic [31:0] jr_pc;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .jump_branch (jump_branch),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .jr_pc       (jr_pc),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .valid_id    (valid_id),
        .fetch_count (fetch_count),
        .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // environment knobs
    int cyc;
    int lat;
    bit rand_ready, rand_stall, rand_jump;
    int ready_low_n, force_stall_n, stale_n;

    // memory model: one outstanding request
    bit          out_valid;
    logic [31:0] out_addr;
    int          due;
    logic [31:0] mem_over[logic [31:0]];
    int          jkind[logic [31:0]];
    logic [31:0] jrval[logic [31:0]];
    int          rdy_low_at[logic [31:0]];

    // program-order reference model
    logic [31:0] exp_pc, cur_pc, tgt;
    bit          is_slot;
    bit          held;
    int          fc_model, bc_model;
    bit          prev_req;
    logic [31:0] prev_addr;
    logic [31:0] dlog[$];

    typedef struct {
        logic [31:0] p;
        int          kind;
        logic [31:0] word;
        logic [31:0] jrv;
        int          rdy_low;
        logic [31:0] e_slot;
        logic [31:0] e_tgt;
        logic [31:0] e_next;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    function automatic logic [31:0] model_target(input int kind, input logic [31:0] p,
                                                 input logic [31:0] w, input logic [31:0] r);
        logic [31:0] np;
        int          off;
        np  = p + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (kind == KR) return r;
        if (kind == KJ) return {np[31:28], w[25:0], 2'b00};
        return np + 32'(off);
    endfunction

    task automatic cycle_body();
        bit          vld, new_i, cons;
        int          kind;
        logic [31:0] jv;
        // memory response for this cycle
        if (out_valid && cyc == due) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(out_addr);
            out_valid   = 1'b0;
        end else if (stale_n > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            stale_n--;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        // observe IF/ID slot
        vld   = valid_id;
        new_i = vld && !held;
        if (!vld) check("instr_zero", instr_id, 32'h0);
        if (held) begin
            check("hold_pc", pc_id, cur_pc);
            check("hold_instr", instr_id, mem_word(cur_pc));
        end
        if (new_i) begin
            check("deliver_pc", pc_id, exp_pc);
            check("deliver_instr", instr_id, mem_word(exp_pc));
            cur_pc = exp_pc;
            dlog.push_back(pc_id);
            fc_model++;
        end
`ifdef FETCH_PERF_COUNTERS_EN
        check("fetch_count", fetch_count, 32'(fc_model));
        check("bubble_count", bubble_count, 32'(bc_model));
`else
        check("fetch_count_off", fetch_count, 32'h0);
        check("bubble_count_off", bubble_count, 32'h0);
`endif
        if (!vld && cyc >= 1) bc_model++;
        // decode behaviour
        if (vld && force_stall_n > 0) begin
            stall = 1'b1;
            force_stall_n--;
        end else if (rand_stall) stall = ($urandom_range(0, 3) == 0);
        else stall = 1'b0;
        cons = vld && !stall;
        if (cons) begin
            kind = 0;
            if (jkind.exists(cur_pc)) kind = jkind[cur_pc];
            else if (rand_jump && !is_slot && $urandom_range(0, 4) == 0) kind = int'($urandom_range(1, 3));
            jv = jrval.exists(cur_pc) ? jrval[cur_pc] : ($urandom & 32'hFFFF_FFFC);
            jump_branch = (kind == KB);
            jump_target = (kind == KJ);
            jump_reg    = (kind == KR);
            jr_pc       = jv;
            if (rdy_low_at.exists(cur_pc)) ready_low_n = rdy_low_at[cur_pc];
            if (is_slot) begin
                exp_pc  = tgt;
                is_slot = 1'b0;
            end else begin
                exp_pc = cur_pc + 32'd4;
                if (kind != 0) begin
                    tgt     = model_target(kind, cur_pc, mem_word(cur_pc), jv);
                    is_slot = 1'b1;
                end
            end
        end else begin
            jump_branch = 1'($urandom);
            jump_target = 1'($urandom);
            jump_reg    = 1'($urandom);
            jr_pc       = $urandom;
        end
        held = vld && stall;
        // memory acceptance
        if (ready_low_n > 0) begin
            imem_ready = 1'b0;
            ready_low_n--;
        end else imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (vld && stall) check("req_in_stall", 32'(imem_req), 32'h0);
        if (prev_req) begin
            check("req_hold", 32'(imem_req), 32'h1);
            check("addr_hold", imem_addr, prev_addr);
        end
        prev_req  = imem_req && !imem_ready;
        prev_addr = imem_addr;
        if (imem_req && imem_ready) begin
            check("one_outstanding", 32'(out_valid), 32'h0);
            out_valid = 1'b1;
            out_addr  = imem_addr;
            due       = cyc + lat;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        cycle_body();
    endtask

    task automatic do_reset(input int stale);
        rst         = 1'b1;
        stall       = 1'b0;
        jump_branch = 1'b0;
        jump_target = 1'b0;
        jump_reg    = 1'b0;
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        out_valid   = 1'b0;
        prev_req    = 1'b0;
        ready_low_n = 0;
        force_stall_n = 0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cyc      = 0;
        exp_pc   = RST_PC;
        cur_pc   = RST_PC;
        is_slot  = 1'b0;
        held     = 1'b0;
        fc_model = 0;
        bc_model = 0;
        dlog.delete();
        stale_n  = stale;
        check("rst_valid", 32'(valid_id), 32'h0);
        check("rst_pc_id", pc_id, 32'h0);
        check("rst_req", 32'(imem_req), 32'h0);
        cycle_body();
    endtask

    task automatic run_deliv(input int n, input int budget);
        int k;
        k = 0;
        while (dlog.size() < n && k < budget) begin
            step();
            k++;
        end
        check("deliveries_in_budget", 32'(dlog.size() >= n), 32'h1);
    endtask

    task automatic clear_prog();
        mem_over.delete();
        jkind.delete();
        jrval.delete();
        rdy_low_at.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; stall = 1'b0; jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0;
        jr_pc = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        rand_ready = 0; rand_stall = 0; rand_jump = 0; lat = 1; cyc = 0;

        vt[0] = '{32'h0000_0100, KB, 32'h1000_0004, 32'h0, 0,
                  32'h0000_0104, 32'h0000_0114, 32'h0000_0118};
        vt[1] = '{32'h0000_0200, KR, 32'h03E0_0008, 32'h0000_8000, 3,
                  32'h0000_0204, 32'h0000_8000, 32'h0000_8004};
        vt[2] = '{32'h3000_0010, KJ, 32'h0800_0040, 32'h0, 0,
                  32'h3000_0014, 32'h3000_0100, 32'h3000_0104};
        vt[3] = '{32'h0000_0500, KB, 32'h1000_FFFE, 32'h0, 0,
                  32'h0000_0504, 32'h0000_04FC, 32'h0000_0500};
        vt[4] = '{32'h0000_0600, KR, 32'h03E0_0008, 32'hFFFF_FFFC, 0,
                  32'h0000_0604, 32'hFFFF_FFFC, 32'h0000_0000};
        vt[5] = '{32'h0000_0700, KR, 32'h03E0_0008, 32'h0000_0020, 1,
                  32'h0000_0704, 32'h0000_0020, 32'h0000_0024};

        // first fetch and issue-to-valid latency with a 1-cycle memory
        clear_prog();
        lat = 1;
        do_reset(0);
        step();
        check("first_req", 32'(imem_req), 32'h1);
        check("first_addr", imem_addr, RST_PC);
        step();
        check("valid_before", 32'(valid_id), 32'h0);
        step();
        check("valid_after_2", 32'(valid_id), 32'h1);
        check("first_pc_id", pc_id, RST_PC);

        // redirect vectors, reached through a jr from the reset address
        for (int unsigned i = 0; i < 6; i++) begin
            clear_prog();
            jkind[RST_PC] = KR;
            jrval[RST_PC] = vt[i].p;
            jkind[vt[i].p] = vt[i].kind;
            mem_over[vt[i].p] = vt[i].word;
            jrval[vt[i].p] = vt[i].jrv;
            if (vt[i].rdy_low > 0) rdy_low_at[vt[i].p] = vt[i].rdy_low;
            lat = 1 + int'(i % 2);
            do_reset(0);
            run_deliv(6, 200);
            if (dlog.size() >= 6) begin
                check("vec_jump_pc", dlog[2], vt[i].p);
                check("vec_slot_pc", dlog[3], vt[i].e_slot);
                check("vec_target_pc", dlog[4], vt[i].e_tgt);
                check("vec_after_target", dlog[5], vt[i].e_next);
            end
        end

        // stall held for 5 cycles on a valid instruction, nothing lost afterwards
        clear_prog();
        lat = 1;
        do_reset(0);
        run_deliv(1, 50);
        d0 = dlog.size();
        force_stall_n = 5;
        run_deliv(d0 + 4, 100);
        check("stall_consumed", 32'(force_stall_n), 32'h0);
        for (int unsigned i = 0; i < dlog.size(); i++)
            check("stall_sequence", dlog[i], RST_PC + 32'(4 * i));

        // reset while a request is outstanding, with stale responses afterwards
        clear_prog();
        lat = 4;
        do_reset(0);
        for (int unsigned k = 0; k < 20 && !out_valid; k++) step();
        check("wait_reached", 32'(out_valid), 32'h1);
        step();
        do_reset(2);
        step();
        check("post_rst_addr", imem_addr, RST_PC);
        run_deliv(1, 50);
        if (dlog.size() >= 1) check("post_rst_first", dlog[0], RST_PC);

        // counters over 10 deliveries at 2-cycle latency
        clear_prog();
        lat = 2;
        do_reset(0);
        run_deliv(10, 200);
`ifdef FETCH_PERF_COUNTERS_EN
        check("fetch_count_10", fetch_count, 32'd10);
        check("bubble_count_10", bubble_count, 32'd21);
`else
        check("fetch_count_zero", fetch_count, 32'h0);
        check("bubble_count_zero", bubble_count, 32'h0);
`endif

        // randomized traffic: latency, ready, stalls, redirects
        for (int unsigned seg = 0; seg < 4; seg++) begin
            clear_prog();
            lat = 1 + int'(seg % 3);
            rand_ready = 1; rand_stall = 1; rand_jump = 1;
            do_reset(seg == 1 ? 1 : 0);
            repeat (1500) step();
            check("random_progress", 32'(dlog.size() > 50), 32'h1);
        end
        rand_ready = 0; rand_stall = 0; rand_jump = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
